mul_arb: RTL and testbench

MUL_ARB -- requirements
Module: mul_arb

---
 rtl/mul_arb.sv | 196 +++++++++++++++++++
 tb/tb_mul_arb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mul_arb
//  Description : N_REQ requesters share one signed Q4.4 multiplier. The
//                combinational arbiter grants one requester per cycle and its
//                operands are captured into a two-stage pipeline: the S1 stage
//                holds the raw Q8.8 product and the S2 stage holds the rounded
//                and saturated Q4.4 result. The output uses a valid/ready
//                handshake and back-pressure stalls the pipeline.
//                Build option: define MUL_ARB_RR_EN for round-robin
//                arbitration. When it is undefined the arbiter uses fixed
//                priority, where the lowest index wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_arb #(
  parameter int N_REQ = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [N_REQ-1:0]                             req,
  input  logic [8*N_REQ-1:0]                           x1_bus,
  input  logic [8*N_REQ-1:0]                           x2_bus,
  output logic [N_REQ-1:0]                             gnt,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [7:0]                                   dout,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] out_id,
  output logic                                         out_sat
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Pipeline state
  logic                   s1_v_q, s1_v_d;
  logic signed [15:0]     s1_prod_q, s1_prod_d;
  logic [ID_W-1:0]        s1_id_q, s1_id_d;
  logic                   s2_v_q, s2_v_d;
  logic [7:0]             s2_dout_q, s2_dout_d;
  logic [ID_W-1:0]        s2_id_q, s2_id_d;
  logic                   s2_sat_q, s2_sat_d;

  // Combinational helpers
  logic                   w_s2_adv;
  logic                   w_s1_adv;
  logic                   w_arb_hit;
  logic [ID_W-1:0]        w_arb_idx;
  logic signed [7:0]      w_x1;
  logic signed [7:0]      w_x2;
  logic signed [15:0]     w_prod;
  logic signed [12:0]     w_r13;
  logic [7:0]             w_res;
  logic                   w_res_sat;

  // A stage can accept new data when it is empty or when its contents move on
  assign w_s2_adv = !s2_v_q || out_ready;
  assign w_s1_adv = !s1_v_q || w_s2_adv;

`ifdef MUL_ARB_RR_EN
  localparam int CW = ID_W + 1;
  localparam logic [ID_W-1:0] c_PTR_RST = ID_W'(N_REQ - 1);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]   w_cand;

  // Round-robin search: start one past the last winner and wrap modulo N_REQ
  always_comb begin
    w_arb_hit = 1'b0;
    w_arb_idx = '0;
    w_cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = {1'b0, ptr_q} + CW'(k);
      if (w_cand >= CW'(N_REQ)) begin
        w_cand = w_cand - CW'(N_REQ);
      end
      if (!w_arb_hit && req[w_cand[ID_W-1:0]]) begin
        w_arb_hit = 1'b1;
        w_arb_idx = w_cand[ID_W-1:0];
      end
    end
  end

  // The pointer moves to the winner, and only in cycles that issue a grant
  always_comb begin
    ptr_d = ptr_q;
    if (|gnt) begin
      ptr_d = w_arb_idx;
    end
  end

  // Pointer register. Reset to N_REQ-1 so that requester 0 is searched first
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= c_PTR_RST;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: the loop runs from high to low so the lowest index wins
  always_comb begin
    w_arb_hit = 1'b0;
    w_arb_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_arb_hit = 1'b1;
        w_arb_idx = ID_W'(i);
      end
    end
  end
`endif

  // Grant only when S1 can take the operands. Reset suppresses all grants
  always_comb begin
    gnt = '0;
    if (rst_n && w_s1_adv && w_arb_hit) begin
      gnt[w_arb_idx] = 1'b1;
    end
  end

  // Select the winner's operands and form the full-precision Q8.8 product
  assign w_x1   = x1_bus[{w_arb_idx, 3'b000} +: 8];
  assign w_x2   = x2_bus[{w_arb_idx, 3'b000} +: 8];
  assign w_prod = w_x1 * w_x2;

  // Round half up to Q4.4 in 13 bits, then clamp to the signed 8-bit range
  always_comb begin
    w_r13     = {s1_prod_q[15], s1_prod_q[15:4]} + {12'd0, s1_prod_q[3]};
    w_res     = w_r13[7:0];
    w_res_sat = 1'b0;
    if (w_r13 > 13'sd127) begin
      w_res     = 8'h7F;
      w_res_sat = 1'b1;
    end else if (w_r13 < -13'sd128) begin
      w_res     = 8'h80;
      w_res_sat = 1'b1;
    end
  end

  // S1 next state: load on advance. It becomes empty when nothing was granted
  always_comb begin
    s1_v_d    = s1_v_q;
    s1_prod_d = s1_prod_q;
    s1_id_d   = s1_id_q;
    if (w_s1_adv) begin
      s1_v_d = |gnt;
      if (|gnt) begin
        s1_prod_d = w_prod;
        s1_id_d   = w_arb_idx;
      end
    end
  end

  // S2 next state: take the S1 result on advance. Hold while stalled
  always_comb begin
    s2_v_d    = s2_v_q;
    s2_dout_d = s2_dout_q;
    s2_id_d   = s2_id_q;
    s2_sat_d  = s2_sat_q;
    if (w_s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_dout_d = w_res;
        s2_id_d   = s1_id_q;
        s2_sat_d  = w_res_sat;
      end
    end
  end

  // Pipeline registers. Reset discards any in-flight results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_prod_q <= '0;
      s1_id_q   <= '0;
      s2_v_q    <= 1'b0;
      s2_dout_q <= '0;
      s2_id_q   <= '0;
      s2_sat_q  <= 1'b0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_prod_q <= s1_prod_d;
      s1_id_q   <= s1_id_d;
      s2_v_q    <= s2_v_d;
      s2_dout_q <= s2_dout_d;
      s2_id_q   <= s2_id_d;
      s2_sat_q  <= s2_sat_d;
    end
  end

  assign out_valid = s2_v_q;
  assign dout      = s2_dout_q;
  assign out_id    = s2_id_q;
  assign out_sat   = s2_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_arb
//  Description : Randomised bench for mul_arb. A transaction-level model
//                predicts the grants and the result stream: a queue of granted
//                transactions with grant timestamps, plus integer arithmetic
//                for the rounding and saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_arb;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int NCYC  = 2500;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N_REQ-1:0]     req;
  logic [8*N_REQ-1:0]   x1_bus;
  logic [8*N_REQ-1:0]   x2_bus;
  logic [N_REQ-1:0]     gnt;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           dout;
  logic [ID_W-1:0]      out_id;
  logic                 out_sat;

  mul_arb #(.N_REQ(N_REQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .x1_bus    (x1_bus),
    .x2_bus    (x2_bus),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .out_id    (out_id),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
               tag, obs, obs, exp, exp, $time);
    end
  endtask

  typedef struct {
    int gcyc;
    int id;
    int d;
    int s;
  } txn_t;

  txn_t       sb[$];
  logic       pend[N_REQ];
  logic [7:0] op1[N_REQ];
  logic [7:0] op2[N_REQ];
  logic [7:0] dir_a[$];
  logic [7:0] dir_b[$];
  int         req_pct;
  int         rdy_pct;
  bit         outs_known;
  bit         post_rst;
`ifdef MUL_ARB_RR_EN
  int         ptr;
`endif

  // Arbitration rule, applied to the pending-request vector
  function automatic int pick(input logic [N_REQ-1:0] r);
`ifdef MUL_ARB_RR_EN
    for (int k = 1; k <= N_REQ; k++) begin
      if (r[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    end
`else
    for (int k = 0; k < N_REQ; k++) begin
      if (r[k]) return k;
    end
`endif
    return -1;
  endfunction

  // Q4.4 x Q4.4: round half up (floor of (p+8)/16), then saturate
  function automatic void model_mul(input logic [7:0] a, input logic [7:0] b,
                                    output int d, output int s);
    int ia, ib, p, t, r;
    ia = (a >= 8'd128) ? int'(a) - 256 : int'(a);
    ib = (b >= 8'd128) ? int'(b) - 256 : int'(b);
    p  = ia * ib;
    t  = p + 8;
    r  = (t >= 0) ? t / 16 : -((-t + 15) / 16);
    if (r > 127) begin
      d = 8'h7F; s = 1;
    end else if (r < -128) begin
      d = 8'h80; s = 1;
    end else begin
      d = (r < 0) ? r + 256 : r; s = 0;
    end
  endfunction

  function automatic logic [7:0] rand_op();
    logic [7:0] corner [9] = '{8'h7F, 8'h80, 8'h00, 8'h01, 8'h08,
                                8'h07, 8'h10, 8'h18, 8'hFF};
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 8)];
    return 8'($urandom);
  endfunction

  initial begin
    logic [N_REQ-1:0] eg;
    bit               can, exp_valid;
    int               k, d, s;
    txn_t             t;

    for (int i = 0; i < N_REQ; i++) begin
      pend[i] = 1'b0; op1[i] = '0; op2[i] = '0;
    end
`ifdef MUL_ARB_RR_EN
    ptr = N_REQ - 1;
`endif
    outs_known = 0;
    post_rst   = 0;
    // Directed products for requester 0: the basic case plus the rounding and saturation corners
    dir_a = '{8'h10, 8'h18, 8'h01, 8'h01, 8'h7F, 8'h80, 8'h80};
    dir_b = '{8'h10, 8'h18, 8'h08, 8'h07, 8'h7F, 8'h80, 8'h7F};

    for (int c = 0; c < NCYC; c++) begin
      // Phase schedule
      rst_n   = 1'b1;
      req_pct = 0;
      rdy_pct = 100;
      if (c < 3) rst_n = 1'b0;
      else if (c < 31) req_pct = 0;
      else if (c < 61) req_pct = 100;
      else if (c < 66) begin req_pct = 100; rdy_pct = 0; end
      else if (c < 81) req_pct = 100;
      else if (c < 85) begin req_pct = 100; rdy_pct = 0; end
      else if (c == 85) begin rst_n = 1'b0; rdy_pct = 0; end
      else if (c < 96) req_pct = 0;
      else if (c < NCYC - 20) begin
        req_pct = 10 + 15 * ((c / 64) % 6);
        rdy_pct = 30 + 14 * ((c / 80) % 6);
        if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
      end
      out_ready = ($urandom_range(0, 99) < rdy_pct);

      // Requesters hold req and operands until granted
      if (!pend[0] && dir_a.size() > 0 && c >= 3) begin
        pend[0] = 1'b1;
        op1[0]  = dir_a.pop_front();
        op2[0]  = dir_b.pop_front();
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < req_pct) begin
          pend[i] = 1'b1;
          op1[i]  = rand_op();
          op2[i]  = rand_op();
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        req[i]          = pend[i];
        x1_bus[8*i +: 8] = op1[i];
        x2_bus[8*i +: 8] = op2[i];
      end

      @(negedge clk);

      // Expected behaviour this cycle
      can       = !(sb.size() >= 2 && !out_ready);
      exp_valid = (sb.size() > 0) && (c >= sb[0].gcyc + 2);
      eg        = '0;
      k         = -1;
      if (rst_n && can) begin
        k = pick(req);
        if (k >= 0) eg[k] = 1'b1;
      end

      check_val("gnt", int'(gnt), int'(eg));
      if (outs_known) begin
        check_val("out_valid", int'(out_valid), int'(exp_valid));
        if (exp_valid) begin
          check_val("dout",    int'(dout),    sb[0].d);
          check_val("out_id",  int'(out_id),  sb[0].id);
          check_val("out_sat", int'(out_sat), sb[0].s);
        end
      end
      if (post_rst) begin
        check_val("rst_dout",    int'(dout),    0);
        check_val("rst_out_id",  int'(out_id),  0);
        check_val("rst_out_sat", int'(out_sat), 0);
      end

      // Model state as of the coming clock edge
      post_rst = !rst_n;
      if (!rst_n) begin
        sb.delete();
`ifdef MUL_ARB_RR_EN
        ptr = N_REQ - 1;
`endif
        outs_known = 1;
      end else begin
        if (exp_valid && out_ready) void'(sb.pop_front());
        if (k >= 0) begin
          model_mul(op1[k], op2[k], d, s);
          t.gcyc = c; t.id = k; t.d = d; t.s = s;
          sb.push_back(t);
          pend[k] = 1'b0;
`ifdef MUL_ARB_RR_EN
          ptr = k;
`endif
        end
      end

      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
